// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_stall_ctrl_pkg
// Shared constants for the MiniMIPS32 stall/flush controller:
//   - stall bus width and the bit index of each stage register
//   - the stall patterns each requester produces
//   - exception codes (EXC_NONE means "no exception")
//   - the exception vector
//   - the controller state encoding
package pipe_stall_ctrl_pkg;

    localparam int STALL_BUS_W   = 6;
    localparam int STALL_PC      = 0;
    localparam int STALL_IF_ID   = 1;
    localparam int STALL_ID_EXE  = 2;
    localparam int STALL_EXE_MEM = 3;
    localparam int STALL_MEM_WB  = 4;
    localparam int STALL_WB      = 5;

    // Each requester holds its own stage and everything upstream of it.
    localparam logic [STALL_BUS_W-1:0] STALL_REQ_MEM = 6'b011111;
    localparam logic [STALL_BUS_W-1:0] STALL_REQ_EXE = 6'b001111;
    localparam logic [STALL_BUS_W-1:0] STALL_REQ_ID  = 6'b000111;
    localparam logic [STALL_BUS_W-1:0] STALL_REQ_IF  = 6'b000011;

    localparam int EXC_CODE_BUS = 5;
    localparam logic [EXC_CODE_BUS-1:0] EXC_INT  = 5'h00;
    localparam logic [EXC_CODE_BUS-1:0] EXC_SYS  = 5'h08;
    localparam logic [EXC_CODE_BUS-1:0] EXC_OV   = 5'h0c;
    localparam logic [EXC_CODE_BUS-1:0] EXC_NONE = 5'h10;
    localparam logic [EXC_CODE_BUS-1:0] EXC_ERET = 5'h11;

    localparam logic [31:0] EXC_ENTRY_ADDR = 32'hBFC00380;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipe_stall_ctrl_outst_cnt.sv
// fetch_outst_cnt
// Counts instruction fetches that the AXI bridge has accepted but whose data
// has not yet returned, plus a drain sub-counter that holds how many of those
// beats must be thrown away after a flush.
// Ports:
//   cpu_clk_50M, cpu_rst : clock, asynchronous active-high reset
//   inc                  : fetch address accepted this cycle
//   dec                  : fetch data returned this cycle
//   disc_load            : load the drain counter with the post-edge count
//   disc_dec             : a beat is being discarded this cycle
//   outst_next           : outstanding count after this edge
//   saturated            : no more fetches may be issued
//   disc_last            : this discarded beat is the last one owed
module fetch_outst_cnt #(
    parameter int MAX_OUTST = 2,
    parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
    input  logic             cpu_clk_50M,
    input  logic             cpu_rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             disc_load,
    input  logic             disc_dec,
    output logic [CNT_W-1:0] outst_next,
    output logic             saturated,
    output logic             disc_last
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

    logic [CNT_W-1:0] outst;
    logic [CNT_W-1:0] disc;

    // A simultaneous accept and return cancel out; a lone accept at the
    // ceiling or a lone return at zero is ignored so the count stays in range.
    always_comb begin
        outst_next = outst;
        if (inc && !dec && (outst != MAX_CNT)) begin
            outst_next = outst + CNT_W'(1);
        end else if (dec && !inc && (outst != '0)) begin
            outst_next = outst - CNT_W'(1);
        end
    end

    assign saturated = (outst == MAX_CNT);
    assign disc_last = disc_dec & (disc == CNT_W'(1));

    // Outstanding fetch count.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            outst <= '0;
        end else begin
            outst <= outst_next;
        end
    end

    // Drain counter: snapshot of the in-flight fetches at flush time, counted
    // down as their data beats come back.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            disc <= '0;
        end else if (disc_load) begin
            disc <= outst_next;
        end else if (disc_dec && (disc != '0)) begin
            disc <= disc - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
// Central stall/flush controller for the 5-stage MiniMIPS32 AXI pipeline.
// Produces the per-stage hold bus and the global flush, and after an
// exception or ERET waits for every in-flight instruction fetch to return
// (discarding it) before redirecting the PC.
// Ports:
//   cpu_clk_50M, cpu_rst      : clock, asynchronous active-high reset
//   stallreq_if/id/exe/mem    : per-stage stall requests
//   mem_exccode, cp0_epc      : exception code from MEM, EPC for ERET
//   inst_req/addr_ok/data_ok  : instruction-fetch AXI bridge handshake
//   stall                     : per-stage hold (bit0 PC ... bit5 WB)
//   flush                     : clear all stage registers
//   fetch_allow               : fetch unit may issue inst_req
//   inst_discard              : drop the current inst_data_ok beat
//   pc_redirect, redirect_pc  : load redirect_pc into the PC this cycle
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int          STALL_W   = STALL_BUS_W,
    parameter int          MAX_OUTST = 2,
    parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_ADDR
) (
    input  logic                    cpu_clk_50M,
    input  logic                    cpu_rst,
    input  logic                    stallreq_if,
    input  logic                    stallreq_id,
    input  logic                    stallreq_exe,
    input  logic                    stallreq_mem,
    input  logic [EXC_CODE_BUS-1:0] mem_exccode,
    input  logic [31:0]             cp0_epc,
    input  logic                    inst_req,
    input  logic                    inst_addr_ok,
    input  logic                    inst_data_ok,
    output logic [STALL_W-1:0]      stall,
    output logic                    flush,
    output logic                    fetch_allow,
    output logic                    inst_discard,
    output logic                    pc_redirect,
    output logic [31:0]             redirect_pc
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    ctrl_state_t      state;
    logic             exc_valid;
    logic             fetch_inc;
    logic             cnt_saturated;
    logic             disc_load;
    logic             disc_dec;
    logic             disc_last;
    logic [CNT_W-1:0] outst_next;

    assign exc_valid    = (mem_exccode != EXC_NONE);
    assign flush        = exc_valid;
    assign fetch_inc    = inst_req & inst_addr_ok;
    assign disc_load    = (state == RUN) & exc_valid & (outst_next != '0);
    assign disc_dec     = (state == DRAIN) & inst_data_ok;
    assign inst_discard = disc_dec;
    assign fetch_allow  = ~cnt_saturated & (state == RUN) & ~flush;

    fetch_outst_cnt #(
        .MAX_OUTST (MAX_OUTST),
        .CNT_W     (CNT_W)
    ) u_outst_cnt (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst     (cpu_rst),
        .inc         (fetch_inc),
        .dec         (inst_data_ok),
        .disc_load   (disc_load),
        .disc_dec    (disc_dec),
        .outst_next  (outst_next),
        .saturated   (cnt_saturated),
        .disc_last   (disc_last)
    );

    // Priority stall encoder: the deepest requester wins. While draining or
    // redirecting, PC and IF/ID are held so no stale instruction enters.
    // A flush overrides everything so the clear reaches every stage.
    always_comb begin
        stall = '0;
        if (stallreq_mem) begin
            stall = STALL_W'(STALL_REQ_MEM);
        end else if (stallreq_exe) begin
            stall = STALL_W'(STALL_REQ_EXE);
        end else if (stallreq_id) begin
            stall = STALL_W'(STALL_REQ_ID);
        end else if (stallreq_if) begin
            stall = STALL_W'(STALL_REQ_IF);
        end
        if (state != RUN) begin
            stall[STALL_PC]    = 1'b1;
            stall[STALL_IF_ID] = 1'b1;
        end
        if (flush) begin
            stall = '0;
        end
    end

    // Flush sequencing. The newest flush always owns the redirect target.
    // A drain ends on the beat that returns its last owed fetch, even if a
    // fresh flush arrives on that same beat, so the controller cannot get
    // stuck waiting for data that will never come.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state       <= RUN;
            pc_redirect <= 1'b0;
            redirect_pc <= EXC_ENTRY;
        end else begin
            if (exc_valid) begin
                redirect_pc <= (mem_exccode == EXC_ERET) ? cp0_epc : EXC_ENTRY;
            end
            pc_redirect <= 1'b0;
            case (state)
                RUN: begin
                    if (exc_valid) begin
                        if (outst_next == '0) begin
                            state       <= REDIRECT;
                            pc_redirect <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (disc_last) begin
                        state       <= REDIRECT;
                        pc_redirect <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (exc_valid) begin
                        pc_redirect <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl
// Self-checking bench for pipe_stall_ctrl: directed scenarios with fixed
// expectations, then randomized traffic against a small behavioural model.
module tb_pipe_stall_ctrl;

    localparam logic [31:0] ENTRY  = 32'hBFC00380;
    localparam logic [4:0]  X_NONE = 5'h10;
    localparam logic [4:0]  X_ERET = 5'h11;
    localparam logic [4:0]  X_INT  = 5'h00;
    localparam logic [4:0]  X_OV   = 5'h0c;

    logic        cpu_clk_50M;
    logic        cpu_rst;
    logic        stallreq_if, stallreq_id, stallreq_exe, stallreq_mem;
    logic [4:0]  mem_exccode;
    logic [31:0] cp0_epc;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [5:0]  stall;
    logic        flush, fetch_allow, inst_discard, pc_redirect;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stall_ctrl dut (
        .cpu_clk_50M  (cpu_clk_50M),
        .cpu_rst      (cpu_rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_exe (stallreq_exe),
        .stallreq_mem (stallreq_mem),
        .mem_exccode  (mem_exccode),
        .cp0_epc      (cp0_epc),
        .inst_req     (inst_req),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .stall        (stall),
        .flush        (flush),
        .fetch_allow  (fetch_allow),
        .inst_discard (inst_discard),
        .pc_redirect  (pc_redirect),
        .redirect_pc  (redirect_pc)
    );

    initial begin
        cpu_clk_50M = 1'b0;
        forever #10 cpu_clk_50M = ~cpu_clk_50M;
    end

    task automatic drive_idle();
        stallreq_if  = 1'b0;
        stallreq_id  = 1'b0;
        stallreq_exe = 1'b0;
        stallreq_mem = 1'b0;
        mem_exccode  = X_NONE;
        cp0_epc      = 32'h0;
        inst_req     = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        cpu_rst = 1'b1;
        #5;
        n_checks++; if (stall !== 6'b0) begin n_fail++; $display("[TB] FAIL reset_stall got %b want %b", stall, 6'b0); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_flush got %b want 0", flush); end
        n_checks++; if (fetch_allow !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_fetch_allow got %b want 1", fetch_allow); end
        n_checks++; if (inst_discard !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_discard got %b want 0", inst_discard); end
        n_checks++; if (pc_redirect !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pc_redirect got %b want 0", pc_redirect); end
        n_checks++; if (redirect_pc !== ENTRY) begin n_fail++; $display("[TB] FAIL reset_redirect_pc got %h want %h", redirect_pc, ENTRY); end
        repeat (2) @(negedge cpu_clk_50M);
        cpu_rst = 1'b0;
    endtask

    task automatic test_stall_priority();
        logic [3:0] req_tab [6];
        logic [5:0] exp_tab [6];
        // {mem, exe, id, if}
        req_tab[0] = 4'b0010; exp_tab[0] = 6'b000111;
        req_tab[1] = 4'b1010; exp_tab[1] = 6'b011111;
        req_tab[2] = 4'b0110; exp_tab[2] = 6'b001111;
        req_tab[3] = 4'b0001; exp_tab[3] = 6'b000011;
        req_tab[4] = 4'b0000; exp_tab[4] = 6'b000000;
        req_tab[5] = 4'b1111; exp_tab[5] = 6'b011111;
        for (int i = 0; i < 6; i++) begin
            @(negedge cpu_clk_50M);
            drive_idle();
            {stallreq_mem, stallreq_exe, stallreq_id, stallreq_if} = req_tab[i];
            #2;
            n_checks++; if (stall !== exp_tab[i]) begin n_fail++; $display("[TB] FAIL prio_%0d stall got %b want %b", i, stall, exp_tab[i]); end
            n_checks++; if (flush !== 1'b0) begin n_fail++; $display("[TB] FAIL prio_%0d flush got %b want 0", i, flush); end
        end
        @(negedge cpu_clk_50M);
        drive_idle();
    endtask

    task automatic test_exception_idle();
        @(negedge cpu_clk_50M);
        drive_idle();
        mem_exccode  = X_INT;
        stallreq_mem = 1'b1;
        #2;
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("[TB] FAIL exc_flush got %b want 1", flush); end
        n_checks++; if (stall !== 6'b0) begin n_fail++; $display("[TB] FAIL exc_stall got %b want %b", stall, 6'b0); end
        n_checks++; if (fetch_allow !== 1'b0) begin n_fail++; $display("[TB] FAIL exc_fetch_allow got %b want 0", fetch_allow); end
        n_checks++; if (pc_redirect !== 1'b0) begin n_fail++; $display("[TB] FAIL exc_early_redirect got %b want 0", pc_redirect); end
        @(negedge cpu_clk_50M);
        drive_idle();
        #2;
        n_checks++; if (pc_redirect !== 1'b1) begin n_fail++; $display("[TB] FAIL exc_pc_redirect got %b want 1", pc_redirect); end
        n_checks++; if (redirect_pc !== ENTRY) begin n_fail++; $display("[TB] FAIL exc_redirect_pc got %h want %h", redirect_pc, ENTRY); end
        n_checks++; if (stall !== 6'b000011) begin n_fail++; $display("[TB] FAIL exc_redirect_stall got %b want %b", stall, 6'b000011); end
        @(negedge cpu_clk_50M);
        #2;
        n_checks++; if (pc_redirect !== 1'b0) begin n_fail++; $display("[TB] FAIL exc_redirect_once got %b want 0", pc_redirect); end
        n_checks++; if (fetch_allow !== 1'b1) begin n_fail++; $display("[TB] FAIL exc_back_to_run got %b want 1", fetch_allow); end
    endtask

    task automatic test_eret_drain();
        for (int i = 0; i < 2; i++) begin
            @(negedge cpu_clk_50M);
            drive_idle();
            inst_req = 1'b1; inst_addr_ok = 1'b1;
        end
        @(negedge cpu_clk_50M);
        drive_idle();
        #2;
        n_checks++; if (fetch_allow !== 1'b0) begin n_fail++; $display("[TB] FAIL eret_full got %b want 0", fetch_allow); end
        @(negedge cpu_clk_50M);
        mem_exccode = X_ERET;
        cp0_epc     = 32'hBFC00100;
        #2;
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("[TB] FAIL eret_flush got %b want 1", flush); end
        @(negedge cpu_clk_50M);
        drive_idle();
        #2;
        n_checks++; if (pc_redirect !== 1'b0) begin n_fail++; $display("[TB] FAIL eret_wait_redirect got %b want 0", pc_redirect); end
        n_checks++; if (fetch_allow !== 1'b0) begin n_fail++; $display("[TB] FAIL eret_drain_allow got %b want 0", fetch_allow); end
        n_checks++; if (stall !== 6'b000011) begin n_fail++; $display("[TB] FAIL eret_drain_stall got %b want %b", stall, 6'b000011); end
        for (int b = 0; b < 2; b++) begin
            @(negedge cpu_clk_50M);
            inst_data_ok = 1'b1;
            #2;
            n_checks++; if (inst_discard !== 1'b1) begin n_fail++; $display("[TB] FAIL eret_discard_%0d got %b want 1", b, inst_discard); end
            n_checks++; if (pc_redirect !== 1'b0) begin n_fail++; $display("[TB] FAIL eret_early_%0d got %b want 0", b, pc_redirect); end
        end
        @(negedge cpu_clk_50M);
        drive_idle();
        #2;
        n_checks++; if (pc_redirect !== 1'b1) begin n_fail++; $display("[TB] FAIL eret_pc_redirect got %b want 1", pc_redirect); end
        n_checks++; if (redirect_pc !== 32'hBFC00100) begin n_fail++; $display("[TB] FAIL eret_redirect_pc got %h want %h", redirect_pc, 32'hBFC00100); end
        @(negedge cpu_clk_50M);
        #2;
        n_checks++; if (fetch_allow !== 1'b1) begin n_fail++; $display("[TB] FAIL eret_back_to_run got %b want 1", fetch_allow); end
    endtask

    task automatic test_outst_simultaneous();
        for (int i = 0; i < 2; i++) begin
            @(negedge cpu_clk_50M);
            drive_idle();
            inst_req = 1'b1; inst_addr_ok = 1'b1;
        end
        @(negedge cpu_clk_50M);
        drive_idle();
        #2;
        n_checks++; if (fetch_allow !== 1'b0) begin n_fail++; $display("[TB] FAIL outst_two got %b want 0", fetch_allow); end
        inst_data_ok = 1'b1;
        @(negedge cpu_clk_50M);
        drive_idle();
        #2;
        n_checks++; if (fetch_allow !== 1'b1) begin n_fail++; $display("[TB] FAIL outst_one got %b want 1", fetch_allow); end
        inst_req = 1'b1; inst_addr_ok = 1'b1; inst_data_ok = 1'b1;
        @(negedge cpu_clk_50M);
        drive_idle();
        #2;
        n_checks++; if (fetch_allow !== 1'b1) begin n_fail++; $display("[TB] FAIL outst_simul got %b want 1", fetch_allow); end
        inst_req = 1'b1; inst_addr_ok = 1'b1;
        @(negedge cpu_clk_50M);
        drive_idle();
        #2;
        n_checks++; if (fetch_allow !== 1'b0) begin n_fail++; $display("[TB] FAIL outst_simul_kept_one got %b want 0", fetch_allow); end
        inst_data_ok = 1'b1;
        repeat (2) @(negedge cpu_clk_50M);
        drive_idle();
        #2;
        n_checks++; if (fetch_allow !== 1'b1) begin n_fail++; $display("[TB] FAIL outst_empty got %b want 1", fetch_allow); end
    endtask

    task automatic test_reset_mid_drain();
        @(negedge cpu_clk_50M);
        drive_idle();
        inst_req = 1'b1; inst_addr_ok = 1'b1;
        @(negedge cpu_clk_50M);
        drive_idle();
        mem_exccode = X_ERET;
        cp0_epc     = 32'h1234_5678;
        @(negedge cpu_clk_50M);
        drive_idle();
        inst_data_ok = 1'b1;
        #2;
        n_checks++; if (redirect_pc !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL rstdrain_target got %h want %h", redirect_pc, 32'h1234_5678); end
        n_checks++; if (inst_discard !== 1'b1) begin n_fail++; $display("[TB] FAIL rstdrain_in_drain got %b want 1", inst_discard); end
        cpu_rst = 1'b1;
        #1;
        n_checks++; if (stall !== 6'b0) begin n_fail++; $display("[TB] FAIL rstdrain_stall got %b want %b", stall, 6'b0); end
        n_checks++; if (inst_discard !== 1'b0) begin n_fail++; $display("[TB] FAIL rstdrain_discard got %b want 0", inst_discard); end
        n_checks++; if (fetch_allow !== 1'b1) begin n_fail++; $display("[TB] FAIL rstdrain_allow got %b want 1", fetch_allow); end
        n_checks++; if (redirect_pc !== ENTRY) begin n_fail++; $display("[TB] FAIL rstdrain_redirect_pc got %h want %h", redirect_pc, ENTRY); end
        @(negedge cpu_clk_50M);
        drive_idle();
        cpu_rst = 1'b0;
        @(negedge cpu_clk_50M);
        #2;
        n_checks++; if (pc_redirect !== 1'b0) begin n_fail++; $display("[TB] FAIL rstdrain_no_redirect got %b want 0", pc_redirect); end
    endtask

    // Reference model: a count of fetches in flight, a count of beats still
    // owed to a drain, a flag for a pending PC load, and the target address.
    task automatic test_random(input int cycles);
        int          m_outst;
        int          m_owed;
        bit          m_redirect;
        logic [31:0] m_target;
        bit          busy, exc, inc, dec;
        int          depth, nxt;
        logic [5:0]  e_stall;
        logic        e_allow;

        @(negedge cpu_clk_50M);
        drive_idle();
        cpu_rst = 1'b1;
        @(negedge cpu_clk_50M);
        cpu_rst    = 1'b0;
        m_outst    = 0;
        m_owed     = 0;
        m_redirect = 1'b0;
        m_target   = ENTRY;

        for (int c = 0; c < cycles; c++) begin
            @(negedge cpu_clk_50M);
            busy         = (m_owed > 0) || m_redirect;
            stallreq_if  = ($urandom_range(0, 3) == 0);
            stallreq_id  = ($urandom_range(0, 3) == 0);
            stallreq_exe = ($urandom_range(0, 3) == 0);
            stallreq_mem = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 11) == 0)
                mem_exccode = $urandom_range(0, 1) ? X_ERET : X_OV;
            else
                mem_exccode = X_NONE;
            cp0_epc      = $urandom;
            exc          = (mem_exccode != X_NONE);
            inst_data_ok = (m_outst > 0) && ($urandom_range(0, 2) == 0);
            e_allow      = (m_outst < 2) && !busy && !exc;
            inst_req     = e_allow && ($urandom_range(0, 1) == 1);
            inst_addr_ok = inst_req && ($urandom_range(0, 1) == 1);

            depth = stallreq_mem ? 5 : stallreq_exe ? 4 : stallreq_id ? 3 : stallreq_if ? 2 : 0;
            e_stall = 6'((1 << depth) - 1);
            if (busy) e_stall = e_stall | 6'b000011;
            if (exc) e_stall = 6'b0;

            #2;
            n_checks++; if (stall !== e_stall) begin n_fail++; $display("[TB] FAIL rnd_stall cyc %0d got %b want %b", c, stall, e_stall); end
            n_checks++; if (flush !== exc) begin n_fail++; $display("[TB] FAIL rnd_flush cyc %0d got %b want %b", c, flush, exc); end
            n_checks++; if (fetch_allow !== e_allow) begin n_fail++; $display("[TB] FAIL rnd_fetch_allow cyc %0d got %b want %b", c, fetch_allow, e_allow); end
            n_checks++; if (inst_discard !== ((m_owed > 0) && inst_data_ok)) begin n_fail++; $display("[TB] FAIL rnd_discard cyc %0d got %b want %b", c, inst_discard, (m_owed > 0) && inst_data_ok); end
            n_checks++; if (pc_redirect !== m_redirect) begin n_fail++; $display("[TB] FAIL rnd_pc_redirect cyc %0d got %b want %b", c, pc_redirect, m_redirect); end
            n_checks++; if (redirect_pc !== m_target) begin n_fail++; $display("[TB] FAIL rnd_redirect_pc cyc %0d got %h want %h", c, redirect_pc, m_target); end

            inc = inst_req && inst_addr_ok;
            dec = inst_data_ok;
            nxt = m_outst + (inc ? 1 : 0) - (dec ? 1 : 0);
            if (nxt > 2) nxt = 2;
            if (nxt < 0) nxt = 0;
            if (exc) m_target = (mem_exccode == X_ERET) ? cp0_epc : ENTRY;
            if (m_redirect) begin
                m_redirect = exc;
            end else if (m_owed > 0) begin
                if (dec) begin
                    m_owed--;
                    if (m_owed == 0) m_redirect = 1'b1;
                end
            end else if (exc) begin
                if (nxt == 0) m_redirect = 1'b1;
                else m_owed = nxt;
            end
            m_outst = nxt;
        end
        @(negedge cpu_clk_50M);
        drive_idle();
    endtask

    initial begin
        cpu_rst = 1'b1;
        drive_idle();
        test_reset();
        test_stall_priority();
        test_exception_idle();
        test_eret_drain();
        test_outst_simultaneous();
        test_reset_mid_drain();
        test_random(400);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
